// File: rtl/radar_pkg.sv
// Shared definitions for the radar chirp path: FSM encoding, parameter-bus
// field layout and the power-on values of the latched chirp fields.
package radar_pkg;

  localparam int unsigned FIELD_W = 32;
  localparam int unsigned PARAM_W = 128;

  localparam int unsigned COUNTER_MAX_LSB = 0;
  localparam int unsigned TUNING_COEF_LSB = 32;
  localparam int unsigned FREQ_OFFSET_LSB = 64;
  localparam int unsigned RSVD_LSB        = 96;

  localparam logic [FIELD_W-1:0] FREQ_OFFSET_RST = 32'h0000_0600;
  localparam logic [FIELD_W-1:0] TUNING_COEF_RST = 32'h0000_0001;
  localparam logic [FIELD_W-1:0] COUNTER_MAX_RST = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } chirp_state_e;

endpackage

// File: rtl/chirp_phase_accum.sv
// Quadratic phase accumulator: phase integrates freq, freq integrates the
// latched tuning coefficient; index counts samples against counter_max.
module chirp_phase_accum
  import radar_pkg::*;
#(
  parameter int unsigned W = FIELD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] freq_offset,
  input  logic [W-1:0] tuning_coef,
  input  logic [W-1:0] counter_max,
  output logic [W-1:0] phase,
  output logic [W-1:0] index,
  output logic         last_c
);

  logic [W-1:0] freq_q, freq_d;
  logic [W-1:0] phase_q, phase_d;
  logic [W-1:0] index_q, index_d;
  logic [W-1:0] tuning_q, tuning_d;
  logic [W-1:0] cmax_q, cmax_d;

  always_comb begin
    freq_d   = freq_q;
    phase_d  = phase_q;
    index_d  = index_q;
    tuning_d = tuning_q;
    cmax_d   = cmax_q;
    if (load) begin
      freq_d   = freq_offset;
      phase_d  = '0;
      index_d  = '0;
      tuning_d = tuning_coef;
      cmax_d   = counter_max;
    end else if (step) begin
      // all three wrap modulo 2^W by construction
      phase_d = phase_q + freq_q;
      freq_d  = freq_q + tuning_q;
      index_d = index_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q   <= '0;
      phase_q  <= '0;
      index_q  <= '0;
      tuning_q <= W'(TUNING_COEF_RST);
      cmax_q   <= W'(COUNTER_MAX_RST);
    end else begin
      freq_q   <= freq_d;
      phase_q  <= phase_d;
      index_q  <= index_d;
      tuning_q <= tuning_d;
      cmax_q   <= cmax_d;
    end
  end

  assign phase  = phase_q;
  assign index  = index_q;
  assign last_c = (index_q == cmax_q);

endmodule

// File: rtl/chirp_phase_gen.sv
// Linear-FM chirp phase generator: handshake FSM with radar_pulse_controller
// driving a quadratic phase accumulator into the DDS phase input.
module chirp_phase_gen
  import radar_pkg::*;
#(
  parameter int unsigned PHASE_W = FIELD_W
) (
  input  logic               clk_fmc150,
  input  logic               resetn_fmc150,
  input  logic               dac_ready,
  input  logic [PARAM_W-1:0] chirp_parameters_in,
  input  logic               chirp_init,
  input  logic               chirp_enable,
  output logic               chirp_ready,
  output logic               chirp_active,
  output logic               chirp_done,
  output logic               chirp_aborted,
  output logic               dds_phase_tvalid,
  output logic [PHASE_W-1:0] dds_phase_tdata,
  output logic [PHASE_W-1:0] sample_index
);

  chirp_state_e state_q, state_d;
  logic ready_q, ready_d;
  logic active_q, active_d;
  logic done_q, done_d;
  logic aborted_q, aborted_d;
  logic tvalid_q, tvalid_d;
  logic accum_load, accum_step, accum_last;
  logic unused_rsvd;

  assign unused_rsvd = ^chirp_parameters_in[PARAM_W-1:RSVD_LSB];

  chirp_phase_accum #(.W(PHASE_W)) u_accum (
    .clk         (clk_fmc150),
    .rst_n       (resetn_fmc150),
    .load        (accum_load),
    .step        (accum_step),
    .freq_offset (chirp_parameters_in[FREQ_OFFSET_LSB +: PHASE_W]),
    .tuning_coef (chirp_parameters_in[TUNING_COEF_LSB +: PHASE_W]),
    .counter_max (chirp_parameters_in[COUNTER_MAX_LSB +: PHASE_W]),
    .phase       (dds_phase_tdata),
    .index       (sample_index),
    .last_c      (accum_last)
  );

  // Next state; status outputs are derived from the next state so they are
  // registered alongside it.
  always_comb begin
    state_d    = state_q;
    aborted_d  = aborted_q;
    accum_load = 1'b0;
    accum_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (chirp_init && chirp_enable && dac_ready) begin
          state_d   = ST_LOAD;
          aborted_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!chirp_enable) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d    = ST_RUN;
          accum_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (!chirp_enable) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (accum_last) begin
          state_d = ST_DONE;
        end else begin
          accum_step = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d  = (state_d == ST_IDLE) && dac_ready;
    active_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d   = (state_d == ST_DONE);
    tvalid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_fmc150 or negedge resetn_fmc150) begin
    if (!resetn_fmc150) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      tvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      tvalid_q  <= tvalid_d;
    end
  end

  assign chirp_ready      = ready_q;
  assign chirp_active     = active_q;
  assign chirp_done       = done_q;
  assign chirp_aborted    = aborted_q;
  assign dds_phase_tvalid = tvalid_q;

endmodule

// File: doc/chirp_phase_gen.md
# chirp_phase_gen

Linear-FM chirp phase generator in the `clk_fmc150` domain. It sits directly upstream of `radar_pulse_controller`, which sends it `chirp_init` and `chirp_enable` and receives `chirp_ready`, `chirp_active` and `chirp_done` in return. On each chirp it latches the chirp parameter bus and produces a quadratic phase sequence, one sample per clock, for the downstream DDS phase input.

## Interface
- `PHASE_W`, 32: phase and frequency accumulator width; only 32 is supported.
- `clk_fmc150`  in  1  DAC/ADC sample clock (245.76 MHz); the only clock.
- `resetn_fmc150`  in  1  reset; asynchronous, active-low.
- `dac_ready`  in  1  level; DAC path is up (status from the FMC150 block).
- `chirp_parameters_in`  in  128  parameter bus, fields:
  - [95:64] freq_offset
  - [63:32] tuning_coef
  - [31:0] counter_max
  - [127:96] ignored
- `chirp_init`  in  1  single-cycle pulse that starts a chirp.
- `chirp_enable`  in  1  level; must stay high for the whole chirp.
- `chirp_ready`  out  1  high while idle and able to accept `chirp_init`.
- `chirp_active`  out  1  high while a chirp is in progress.
- `chirp_done`  out  1  single-cycle pulse at the end of a chirp.
- `chirp_aborted`  out  1  sticky flag: the last chirp ended because `chirp_enable` dropped.
- `dds_phase_tvalid`  out  1  phase sample valid; there is no backpressure.
- `dds_phase_tdata`  out  32  phase sample.
- `sample_index`  out  32  index of the current sample, 0..counter_max.

## Operation
- **States:** IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `chirp_ready` = `dac_ready`.
  - Goes to LOAD when `chirp_init & chirp_enable & dac_ready`.
  - `chirp_init` without `chirp_enable`, or while `dac_ready` is low, is ignored.
- **LOAD (one cycle)**
  - Latch the three fields of `chirp_parameters_in`.
  - freq ← freq_offset, phase ← 0, index ← 0, `chirp_aborted` ← 0.
- **RUN (one sample per cycle)**
  - Outputs: `dds_phase_tdata` = phase, `sample_index` = index, `dds_phase_tvalid` = 1.
  - Updates each cycle: phase ← phase + freq, freq ← freq + tuning_coef, index ← index + 1.
  - All arithmetic is unsigned and wraps mod 2^32; there is no saturation.
  - Exit to DONE after the sample with index == counter_max. A chirp is therefore counter_max+1 samples; counter_max = 0 gives one sample.
- **Abort:** `chirp_enable` low in LOAD or RUN moves to DONE on the next edge and sets `chirp_aborted`. The sample in the abort cycle is not emitted.
- **DONE (one cycle):** `chirp_done` = 1, then return to IDLE.
- **Input changes:**
  - `chirp_init` in LOAD, RUN or DONE is ignored; it is not queued.
  - Changes to `chirp_parameters_in` after LOAD have no effect until the next chirp.
- **`dac_ready` dropping mid-chirp:** does not stop the chirp; it only gates the next start.
- **Reset:** asynchronous from any state. Returns to IDLE immediately; all outputs and accumulators go to 0. No `chirp_done` is issued for an interrupted chirp.

## Timing
- All outputs are registered.
- **Reset values:**
  - `chirp_ready`, `chirp_active`, `chirp_done`, `chirp_aborted`, `dds_phase_tvalid` = 0.
  - `dds_phase_tdata`, `sample_index` = 0.
  - After reset release, `chirp_ready` rises on the first edge with `dac_ready` = 1.
- **Normal chirp:** `chirp_init` sampled at edge E0.
  - After E0: state LOAD, `chirp_ready` = 0, `chirp_active` = 1.
  - After E1: first sample (index 0, phase 0) with `tvalid` = 1.
  - After E1+N (N = counter_max): last sample.
  - After E2+N: `tvalid` = 0, `chirp_active` = 0, `chirp_done` = 1.
  - After E3+N: IDLE, `chirp_ready` = `dac_ready`.
- **Latencies:**
  - `chirp_init` to first valid sample: 2 cycles.
  - Minimum spacing between `chirp_init` pulses that are accepted: N+4 cycles.
- **Abort:** `chirp_enable` seen low at edge Ea. After Ea: `tvalid` = 0, `chirp_done` = 1, `chirp_aborted` = 1. After Ea+1: IDLE.
- `chirp_active` and `dds_phase_tvalid` are never high in the same cycle as `chirp_done`.

## Structure
- **Shared package** (`radar_pkg`):
  - State encoding: 2 bits (IDLE=0, LOAD=1, RUN=2, DONE=3).
  - Bit positions of the `chirp_parameters` fields.
  - Reset defaults for the fields: freq_offset 0x0600, tuning_coef 1, counter_max 0x0FFF.
- **Sub-module** `chirp_phase_accum`: holds freq, phase and index, with load/step inputs and a last-sample flag output.
- The FSM and handshake logic stay in the top level.

## Test plan
- **Basic chirp:** freq_offset 0x600, tuning_coef 1, counter_max 3, `init` pulse with `enable` high → tdata 0x0, 0x600, 0xC01, 0x1203 on 4 consecutive `tvalid` cycles starting 2 cycles after `init`; `done` one cycle after the last sample; `ready` returns 1 cycle after `done`.
- **Wrap and single sample:**
  - freq_offset 0xFFFFFFFF, tuning_coef 1, counter_max 2 → tdata 0x0, 0xFFFFFFFF, 0xFFFFFFFF (the freq register wrapped to 0).
  - counter_max 0 → exactly 1 sample, then `done`.
- **Gating:**
  - `init` with `enable` low → no state change.
  - `init` with `dac_ready` low → no state change, `ready` stays 0.
  - Second `init` during RUN → ignored; sample count unchanged.
- **Abort:** counter_max 100, drop `enable` at sample 10 → `tvalid` falls, `done` = 1 and `aborted` = 1 on the next cycle, then IDLE. `aborted` clears on the next LOAD.
- **Parameter isolation:** change `chirp_parameters_in` during RUN → the current sequence is unchanged; the next chirp uses the new values.
- **Async reset mid-RUN:** all outputs go to 0 immediately with no `done` pulse; `ready` reasserts on the first edge after release with `dac_ready` = 1.
